led_share_scheduler: RTL and testbench
======================================

Name: led_share_scheduler

Overview:
- Time-shares the single user LED between NUM_REQ independent requesters (status sources, debug flags, etc.).
- Each requester presents a blink pattern. Requesters are granted in round-robin order for a fixed slot of SLOT_TICKS ticks, with a dark gap of GAP_TICKS ticks between slots.
- Sits between the pattern sources and the top-level LED pin.
- Contains its own tick prescaler, so it scales from simulation-sized to 16MHz board-sized timing purely by parameters.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- TICK_DIV, 1<<20, clock cycles per tick (>=2).
- SLOT_TICKS, 8, ticks per granted slot (>=1).
- GAP_TICKS, 2, dark ticks between slots (>=0).
- PATTERN_W, 8, bits per blink pattern (>=2).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  per-requester request level.
- i_pattern  in  NUM_REQ*PATTERN_W  requester k pattern at bits [k*PATTERN_W +: PATTERN_W].
- o_grant  out  NUM_REQ  one-hot current owner; 0 when no owner.
- o_led  out  1  LED drive.
- o_busy  out  1  high in GRANT or GAP.
- o_tick  out  1  one-cycle tick strobe, for debug.

Behaviour:
- Reset:
  - All state and outputs clear immediately on i_rst_n low, regardless of clock.
  - Values in reset: o_grant=0, o_led=0, o_busy=0, o_tick=0, prescaler=0, state=IDLE.
  - The last-granted pointer resets to NUM_REQ-1, so requester 0 wins first.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1 that wraps to 0.
  - o_tick is registered and high for exactly the cycle where the counter equals TICK_DIV-1.
  - The prescaler is never reset or realigned by the FSM, so the tick period is exactly TICK_DIV cycles.
- FSM states: IDLE, GRANT, GAP. All outputs are registered.
- IDLE:
  - Evaluated every cycle (not tick-aligned).
  - If any i_req bit is high, select the first requesting index searching upward from last_granted+1, modulo NUM_REQ.
  - On the next edge: latch that requester's pattern into a shift/index register, set o_grant one-hot, set last_granted, set bit index=0, slot count=0, and enter GRANT.
  - Latency from request sample to grant is 1 cycle.
- GRANT:
  - o_led = latched_pattern[bit_idx]; o_led and o_grant change on the same edge.
  - On each o_tick: bit_idx = (bit_idx+1) mod PATTERN_W and slot count increments.
  - After the SLOT_TICKS-th tick, the next state is GAP, or IDLE if GAP_TICKS=0.
  - The first slot tick may be partial because the grant is not tick-aligned.
  - i_pattern changes during GRANT are ignored, since the pattern was latched at grant.
- Early release: if the owner's i_req is low on any GRANT cycle, leave GRANT on the next edge as if the slot had expired (to GAP, or IDLE if GAP_TICKS=0).
- GAP:
  - o_grant=0 and o_led=0.
  - Return to IDLE after GAP_TICKS ticks; the first gap tick may be partial.
- Entering GRANT directly from GAP is not allowed; arbitration always passes through IDLE, which costs one cycle.
- Requests from non-owners during GRANT or GAP are held off, with no queueing beyond the live i_req level.
- o_busy = (state != IDLE).
- Counter widths:
  - Slot and gap counters are sized to hold SLOT_TICKS and GAP_TICKS respectively.
  - bit_idx is sized for PATTERN_W.
  - No counter may overflow for any legal parameter value.
- A tick coinciding with an early release takes the early-release path; the bit_idx update that tick is don't-care.

Test Plan:
Bench parameters: NUM_REQ=4, TICK_DIV=4, SLOT_TICKS=3, GAP_TICKS=1, PATTERN_W=4.
1. Reset: hold i_rst_n=0 for 5 cycles with requests active -> all outputs 0. Assert reset mid-GRANT -> o_grant/o_led drop to 0 without a clock edge.
2. Tick period: run 40 cycles -> o_tick high exactly every 4th cycle, unaffected by grant activity.
3. Single requester: i_req=4'b0010, pattern1=4'b0101 -> o_grant=0010 one cycle later, with o_led=1 until the next tick, then 0, then 1. Grant clears after the 3rd tick, a 1-tick dark gap follows, then the requester is re-granted.
4. Round-robin: i_req=4'b1111 held -> grant order 0001, 0010, 0100, 1000, 0001, each slot separated by a gap with o_grant=0 and o_led=0.
5. Early release: requester 2 granted, drops i_req after 5 cycles -> o_grant=0 on the next edge and a gap follows. Next grant goes to requester 3 if it is requesting, else wraps.
6. Pattern latch: change pattern2 from 4'b1111 to 4'b0000 mid-slot -> o_led keeps following 4'b1111 until the slot ends.

Source files
------------

// File: rtl/led_share_scheduler.sv
// led_share_scheduler: time-shares one LED between NUM_REQ pattern sources.
// Round-robin grants of SLOT_TICKS ticks, separated by GAP_TICKS dark ticks,
// timed by an internal free-running tick prescaler.
module led_share_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int TICK_DIV   = 1 << 20,
  parameter int SLOT_TICKS = 8,
  parameter int GAP_TICKS  = 2,
  parameter int PATTERN_W  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*PATTERN_W-1:0]   i_pattern,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_led,
  output logic                           o_busy,
  output logic                           o_tick
);

  localparam int PRESC_W   = $clog2(TICK_DIV);
  localparam int SLOT_W    = $clog2(SLOT_TICKS + 1);
  localparam int GAP_W     = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int GAP_LAST  = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam int IDX_W     = $clog2(PATTERN_W);
  localparam int OWN_W     = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 tick_q, tick_d;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 led_q, led_d;
  logic                 busy_q, busy_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0]     bit_q, bit_d, bit_nxt;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [OWN_W-1:0]     last_q, last_d;

  logic [PATTERN_W-1:0] pat_arr [NUM_REQ];
  logic                 found;
  logic [OWN_W-1:0]     sel;
  logic [OWN_W-1:0]     cand;
  int                   idx;

  // Prescaler next value; tick is flagged one cycle ahead so the registered
  // strobe lines up with the cycle where the counter sits at TICK_DIV-1.
  always_comb begin
    presc_d = (presc_q == PRESC_W'(TICK_DIV - 1)) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_d == PRESC_W'(TICK_DIV - 1));
  end

  // Free-running prescaler and tick strobe, never realigned by the FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Unpack the flat pattern bus and pick the next requester after last owner.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      pat_arr[k] = i_pattern[k*PATTERN_W +: PATTERN_W];
    end
    found = 1'b0;
    sel   = last_q;
    cand  = last_q;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = OWN_W'(idx);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // FSM next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    led_d   = led_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    last_d  = last_q;
    bit_nxt = (bit_q == IDX_W'(PATTERN_W - 1)) ? '0 : bit_q + 1'b1;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        led_d   = 1'b0;
        if (found) begin
          state_d = GRANT;
          grant_d = NUM_REQ'(1) << sel;
          pat_d   = pat_arr[sel];
          led_d   = pat_arr[sel][0];
          bit_d   = '0;
          slot_d  = '0;
          last_d  = sel;
        end
      end
      GRANT: begin
        if (!i_req[last_q]) begin
          // Owner withdrew: release as though the slot had run out.
          state_d = (GAP_TICKS > 0) ? GAP : IDLE;
          grant_d = '0;
          led_d   = 1'b0;
          gap_d   = '0;
        end else if (tick_q) begin
          if (slot_q == SLOT_W'(SLOT_TICKS - 1)) begin
            state_d = (GAP_TICKS > 0) ? GAP : IDLE;
            grant_d = '0;
            led_d   = 1'b0;
            gap_d   = '0;
          end else begin
            slot_d = slot_q + 1'b1;
            bit_d  = bit_nxt;
            led_d  = pat_q[bit_nxt];
          end
        end
      end
      GAP: begin
        grant_d = '0;
        led_d   = 1'b0;
        if (tick_q) begin
          if (gap_q == GAP_W'(GAP_LAST)) state_d = IDLE;
          else                           gap_d   = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        led_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state and output registers; pointer starts at NUM_REQ-1 so 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      pat_q   <= '0;
      bit_q   <= '0;
      slot_q  <= '0;
      gap_q   <= '0;
      last_q  <= OWN_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
    end
  end

  assign o_grant = grant_q;
  assign o_led   = led_q;
  assign o_busy  = busy_q;
  assign o_tick  = tick_q;

endmodule

// File: tb/tb_led_share_scheduler.sv
// Testbench for led_share_scheduler: directed steps with a grant scoreboard.
module tb_led_share_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int TICK_DIV   = 4;
  localparam int SLOT_TICKS = 3;
  localparam int GAP_TICKS  = 1;
  localparam int PATTERN_W  = 4;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic [NUM_REQ-1:0]           req = '0;
  logic [NUM_REQ*PATTERN_W-1:0] pattern = '0;
  logic [NUM_REQ-1:0]           grant;
  logic                         led, busy, tick;

  led_share_scheduler #(
    .NUM_REQ(NUM_REQ), .TICK_DIV(TICK_DIV), .SLOT_TICKS(SLOT_TICKS),
    .GAP_TICKS(GAP_TICKS), .PATTERN_W(PATTERN_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_pattern(pattern),
    .o_grant(grant), .o_led(led), .o_busy(busy), .o_tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0]   grant;
    logic [PATTERN_W-1:0] pat;
    bit                   early;
  } item_t;

  item_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [NUM_REQ-1:0] g, input logic [PATTERN_W-1:0] p, input bit e);
    item_t it;
    it.grant = g; it.pat = p; it.early = e;
    sb.push_back(it);
  endtask

  task automatic wait_grant(input logic [NUM_REQ-1:0] val, input int budget, input string tag);
    int n = 0;
    while (grant !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(grant, val, tag);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(busy, 0, tag);
  endtask

  // Monitor state
  item_t              cur;
  logic [NUM_REQ-1:0] prev_grant = '0;
  logic               prev_busy = 1'b0;
  int slot_ticks = 0, gap_ticks = 0, since_tick = 0, grants_seen = 0;
  bit in_gap = 0, tick_seen = 0;

  // Output monitor: pops the scoreboard on every new grant and checks
  // tick spacing, LED bit sequence, slot length and gap behaviour.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = '0; prev_busy = 1'b0; in_gap = 0;
      tick_seen = 0; since_tick = 0; slot_ticks = 0; gap_ticks = 0;
    end else begin
      since_tick++;
      if (tick) begin
        if (tick_seen) check(since_tick, TICK_DIV, "tick_period");
        tick_seen = 1;
        since_tick = 0;
      end
      if (grant !== '0 && prev_grant === '0) begin
        check(sb.size() != 0, 1, "sb_nonempty");
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          check(grant, cur.grant, "grant_order");
        end
        check(prev_busy, 0, "via_idle");
        slot_ticks = 0;
        grants_seen++;
      end
      if (grant !== '0) begin
        check($onehot(grant), 1, "grant_onehot");
        check(led, cur.pat[slot_ticks % PATTERN_W], "led_bit");
        if (tick) slot_ticks++;
      end
      if (grant === '0 && prev_grant !== '0) begin
        if (!cur.early) check(slot_ticks, SLOT_TICKS, "slot_len");
        check(busy, 1, "gap_entry");
        in_gap = 1;
        gap_ticks = 0;
      end
      if (in_gap) begin
        if (busy) begin
          check(led, 0, "gap_led");
          check(grant, 0, "gap_grant");
          if (tick) gap_ticks++;
        end else begin
          check(gap_ticks, GAP_TICKS, "gap_len");
          in_gap = 0;
        end
      end
      prev_grant = grant;
      prev_busy  = busy;
    end
  end

  initial begin
    int ticks;
    int n;
    int base;

    // Reset held with all requests active
    req = 4'b1111;
    repeat (5) @(negedge clk);
    check(grant, 0, "rst_grant");
    check(led, 0, "rst_led");
    check(busy, 0, "rst_busy");
    check(tick, 0, "rst_tick");
    req = '0;
    #1 rst_n = 1'b1;

    // Tick period with no activity
    ticks = 0;
    repeat (40) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    check(ticks, 40 / TICK_DIV, "tick_count");

    // Single requester, normal slot then re-grant cut short
    pattern[1*PATTERN_W +: PATTERN_W] = 4'b0101;
    push(4'b0010, 4'b0101, 0);
    push(4'b0010, 4'b0101, 1);
    req = 4'b0010;
    @(negedge clk);
    check(grant, 4'b0010, "single_latency");
    check(led, 1, "single_led0");
    check(busy, 1, "single_busy");
    wait_grant(4'b0000, 40, "single_release");
    wait_grant(4'b0010, 40, "single_regrant");
    req = '0;
    wait_idle(40, "single_idle");

    // Reset asserted in the middle of a grant
    pattern[0 +: PATTERN_W] = 4'b1111;
    push(4'b0001, 4'b1111, 1);
    req = 4'b0001;
    @(negedge clk);
    check(grant, 4'b0001, "midrst_pre_grant");
    check(led, 1, "midrst_pre_led");
    #2 rst_n = 1'b0;
    #1;
    check(grant, 0, "midrst_grant");
    check(led, 0, "midrst_led");
    check(busy, 0, "midrst_busy");
    sb.delete();

    // Round-robin with all requesters active
    pattern = {4'b0011, 4'b1100, 4'b0110, 4'b1001};
    push(4'b0001, 4'b1001, 0);
    push(4'b0010, 4'b0110, 0);
    push(4'b0100, 4'b1100, 0);
    push(4'b1000, 4'b0011, 0);
    push(4'b0001, 4'b1001, 1);
    req = 4'b1111;
    repeat (2) @(negedge clk);
    base = grants_seen;
    #1 rst_n = 1'b1;
    n = 0;
    while (grants_seen < base + 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(grants_seen - base, 5, "rr_grant_count");
    req = '0;
    wait_idle(40, "rr_idle");

    // Early release by requester 2, requester 3 picks up next
    pattern[2*PATTERN_W +: PATTERN_W] = 4'b1010;
    pattern[3*PATTERN_W +: PATTERN_W] = 4'b0110;
    push(4'b0100, 4'b1010, 1);
    push(4'b1000, 4'b0110, 1);
    req = 4'b1100;
    wait_grant(4'b0100, 20, "early_grant2");
    repeat (5) @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    check(grant, 0, "early_release");
    check(busy, 1, "early_gap");
    wait_grant(4'b1000, 40, "early_next3");
    req = '0;
    wait_idle(40, "early_idle");

    // Pattern latched at grant time
    pattern[2*PATTERN_W +: PATTERN_W] = 4'b1111;
    push(4'b0100, 4'b1111, 0);
    req = 4'b0100;
    wait_grant(4'b0100, 20, "latch_grant");
    repeat (3) @(negedge clk);
    pattern[2*PATTERN_W +: PATTERN_W] = 4'b0000;
    @(negedge clk);
    check(led, 1, "latch_led");
    wait_grant(4'b0000, 40, "latch_release");
    req = '0;
    wait_idle(40, "latch_idle");

    check(sb.size(), 0, "sb_drained");
    check(grants_seen, 11, "total_grants");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
